// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: Wishbone-controlled sequencer for an 8-bit serial ADC.
// A START write or an auto-timer expiry runs one conversion:
//   SETUP -> 3 command bits -> 1 null bit -> 8 data bits -> HOLD.
// Bus handshake: an access is stb & cyc. When an access is seen while the
// internal ack is low, the register read/write happens on that clock edge
// and ack is high for the following cycle. wb_ack_o is qualified by
// stb & cyc, so back-to-back accesses take two cycles each.
`timescale 1ns/1ps
module adc_scan_ctrl #(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic        irq,
    output logic [2:0]  dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_NULLB, S_DATA, S_HOLD
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic        phase_q;              // 0: sclk low phase, 1: sclk high phase
    logic [2:0]  bit_q;
    logic [7:0]  shift_q, shift_next, data_q;
    logic        ch_lat_q;
    logic        ack_q, irq_q;
    logic [31:0] dat_o_q, rd_data;
    logic        auto_q, irq_en_q, ch_q, irq_en_d;
    logic        done_q, ovr_q, done_d, ovr_d;
    logic [23:0] period_q, timer_q, timer_d;

    logic       req, access, wr, rd;
    logic [2:0] reg_sel;
    logic       phase_end, bit_end, in_bits, busy;
    logic       start_wr, timer_run, timer_exp, trigger, accept, overrun;
    logic       done_set, cmd_bit, ch_sel;
    logic       bus_unused;

    assign req      = wb_stb_i & wb_cyc_i;
    assign access   = req & ~ack_q;
    assign wr       = access & wb_we_i;
    assign rd       = access & ~wb_we_i;
    assign reg_sel  = wb_adr_i[4:2];
    assign bus_unused = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:24]};

    assign phase_end = (cnt_q == DIV_LAST);
    assign in_bits   = (state_q == S_CMD) || (state_q == S_NULLB) || (state_q == S_DATA);
    assign bit_end   = phase_end & phase_q;
    assign busy      = (state_q != S_IDLE);

    assign start_wr  = wr && (reg_sel == 3'd0) && wb_dat_i[0];
    assign timer_run = auto_q && (period_q != 24'd0);
    assign timer_exp = timer_run && (timer_q == period_q - 24'd1);
    assign trigger   = start_wr | timer_exp;
    assign accept    = trigger & ~busy;
    assign overrun   = trigger & busy;
    // A START write that also changes CH uses the newly written channel.
    assign ch_sel    = start_wr ? wb_dat_i[3] : ch_q;

    assign shift_next = {shift_q[6:0], adc_dout};
    assign done_set   = (state_q == S_DATA) && bit_end && (bit_q == 3'd7);

    // Command word MSB-first: start bit, single-ended bit, channel.
    assign cmd_bit  = (bit_q == 3'd2) ? ch_lat_q : 1'b1;
    assign adc_cs_n = (state_q == S_IDLE) || (state_q == S_HOLD);
    assign adc_sclk = in_bits & phase_q;
    assign adc_din  = (state_q == S_CMD) & cmd_bit;

    assign wb_ack_o    = req & ack_q;
    assign wb_dat_o    = dat_o_q;
    assign irq         = irq_q;
    assign dbg_state_o = state_q;

    // Conversion sequencer next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trigger)                      state_d = S_SETUP;
            S_SETUP: if (phase_end)                    state_d = S_CMD;
            S_CMD:   if (bit_end && bit_q == 3'd2)     state_d = S_NULLB;
            S_NULLB: if (bit_end)                      state_d = S_DATA;
            S_DATA:  if (bit_end && bit_q == 3'd7)     state_d = S_HOLD;
            S_HOLD:  if (phase_end)                    state_d = S_IDLE;
            default:                                   state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any conversion on the next edge.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Phase/bit timing: counters restart on every state change.
    always_ff @(posedge clk) begin
        if (rst || state_d != state_q || state_q == S_IDLE) begin
            cnt_q   <= 8'd0;
            phase_q <= 1'b0;
            bit_q   <= 3'd0;
        end else if (phase_end) begin
            cnt_q <= 8'd0;
            if (in_bits) begin
                phase_q <= ~phase_q;
                if (phase_q) bit_q <= bit_q + 3'd1;
            end
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Result shift register (sampled at the end of each high phase) and channel latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= 8'd0;
            ch_lat_q <= 1'b0;
        end else begin
            if (state_q == S_DATA && bit_end) shift_q <= shift_next;
            if (accept)                       ch_lat_q <= ch_sel;
        end
    end

    // Sticky flags, timer and irq next values; set wins over clear.
    always_comb begin
        done_d = done_q;
        if ((wr && reg_sel == 3'd1 && wb_dat_i[1]) || (rd && reg_sel == 3'd2)) done_d = 1'b0;
        if (done_set) done_d = 1'b1;
        ovr_d = ovr_q;
        if (wr && reg_sel == 3'd1 && wb_dat_i[2]) ovr_d = 1'b0;
        if (overrun) ovr_d = 1'b1;
        irq_en_d = (wr && reg_sel == 3'd0) ? wb_dat_i[2] : irq_en_q;
        timer_d = timer_q + 24'd1;
        if (!timer_run || timer_exp)               timer_d = 24'd0;
        if (wr && reg_sel == 3'd0 && !wb_dat_i[1]) timer_d = 24'd0;
        if (wr && reg_sel == 3'd3)                 timer_d = 24'd0;
    end

    // Register read mux; unused bits read as zero.
    always_comb begin
        rd_data = 32'd0;
        case (reg_sel)
            3'd0:    rd_data = {28'd0, ch_q, irq_en_q, auto_q, 1'b0};
            3'd1:    rd_data = {29'd0, ovr_q, done_q, busy};
            3'd2:    rd_data = {24'd0, data_q};
            3'd3:    rd_data = {8'd0, period_q};
            default: rd_data = 32'd0;
        endcase
    end

    // Bus-visible registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 1'b0;
            dat_o_q  <= 32'd0;
            auto_q   <= 1'b0;
            irq_en_q <= 1'b0;
            ch_q     <= 1'b0;
            period_q <= 24'd0;
            timer_q  <= 24'd0;
            data_q   <= 8'd0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q <= access;
            if (rd) dat_o_q <= rd_data;
            if (wr && reg_sel == 3'd0) begin
                auto_q <= wb_dat_i[1];
                ch_q   <= wb_dat_i[3];
            end
            if (wr && reg_sel == 3'd3) period_q <= wb_dat_i[23:0];
            if (done_set) data_q <= shift_next;
            irq_en_q <= irq_en_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            irq_q    <= irq_en_d & done_d;
        end
    end
endmodule
